// File: rtl/bidir_pad_reg_pkg.sv
// -----------------------------------------------------------------------------
// bidir_pad_reg_pkg
// Purpose : shared defaults and types for the bidirectional pad register bank.
// Contents: BIDIR_WIDTH_DEF  - default pad bits per bank
//           BIDIR_SYNC_DEF   - default read-back synchronizer depth
//           pad_vec_t        - one bank's worth of pad bits
// -----------------------------------------------------------------------------
package bidir_pad_reg_pkg;

    localparam int BIDIR_WIDTH_DEF = 16;
    localparam int BIDIR_SYNC_DEF  = 2;

    typedef logic [BIDIR_WIDTH_DEF-1:0] pad_vec_t;

endpackage : bidir_pad_reg_pkg

// File: rtl/bidir_pad_reg_sync_ff_chain.sv
// -----------------------------------------------------------------------------
// sync_ff_chain
// Purpose : per-bit flop chain used to bring the pad levels into the clock
//           domain. Every stage clears to 0 on a synchronous active-low reset.
// Ports   : clock    in   rising-edge clock
//           reset_n  in   synchronous active-low reset
//           d        in   WIDTH  asynchronous input levels
//           q        out  WIDTH  output of the last stage
// -----------------------------------------------------------------------------
module sync_ff_chain
    import bidir_pad_reg_pkg::*;
#(
    parameter int WIDTH  = BIDIR_WIDTH_DEF,
    parameter int STAGES = BIDIR_SYNC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < 2) begin : g_bad_depth
        $error("sync_ff_chain: STAGES must be at least 2");
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/bidir_pad_reg.sv
// -----------------------------------------------------------------------------
// bidir_pad_reg
// Purpose : one 16-bit bank of bidirectional daughterboard pads. Drive enable
//           and drive value are registered, the pad is released (high-Z) when
//           its registered enable is clear, and the pad level is resynchronized
//           for read-back with optional edge pulses on released bits.
// Config  : BIDIR_PAD_REG_EDGE_EN - when defined, edge_rise/edge_fall pulse on
//           synchronized transitions; when undefined they are tied to 0 and no
//           history register is built. Ports are identical in both builds.
// Ports   : clock      in     rising-edge clock
//           reset_n    in     synchronous active-low reset
//           tristate   inout  WIDTH  pad bus
//           oe         in     WIDTH  per-bit output enable (1 = drive)
//           reg_val    in     WIDTH  per-bit drive value
//           pin_in     out    WIDTH  synchronized pad level
//           edge_rise  out    WIDTH  1-cycle pulse on synchronized 0->1
//           edge_fall  out    WIDTH  1-cycle pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module bidir_pad_reg
    import bidir_pad_reg_pkg::*;
#(
    parameter int WIDTH       = BIDIR_WIDTH_DEF,
    parameter int SYNC_STAGES = BIDIR_SYNC_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    inout  wire  [WIDTH-1:0] tristate,
    input  logic [WIDTH-1:0] oe,
    input  logic [WIDTH-1:0] reg_val,
    output logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] edge_rise,
    output logic [WIDTH-1:0] edge_fall
);

    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] val_q;

    // Enable and value share one register stage so a simultaneous change of
    // both reaches the pad in the same cycle with no per-bit skew.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            oe_q  <= '0;
            val_q <= '0;
        end else begin
            oe_q  <= oe;
            val_q <= reg_val;
        end
    end

    // Pad driven purely from flops, never from the raw oe/reg_val inputs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign tristate[i] = oe_q[i] ? val_q[i] : 1'bz;
    end

    sync_ff_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (tristate),
        .q       (pin_in)
    );

`ifdef BIDIR_PAD_REG_EDGE_EN
    logic [WIDTH-1:0] pin_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pin_d <= '0;
        end else begin
            pin_d <= pin_in;
        end
    end

    // Bits we are driving ourselves are masked so our own writes never look
    // like external activity.
    assign edge_rise = ~oe_q &  pin_in & ~pin_d;
    assign edge_fall = ~oe_q & ~pin_in &  pin_d;
`else
    assign edge_rise = '0;
    assign edge_fall = '0;
`endif

endmodule : bidir_pad_reg

// File: tb/tb_bidir_pad_reg.sv
module tb_bidir_pad_reg;
    import bidir_pad_reg_pkg::*;

    localparam int W = BIDIR_WIDTH_DEF;
    localparam int S = BIDIR_SYNC_DEF;

    logic     clock = 1'b0;
    logic     reset_n;
    pad_vec_t oe, reg_val, ext_en, ext_val;
    pad_vec_t pin_in, edge_rise, edge_fall;
    wire  [W-1:0] pad;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    pad_vec_t m_oe_q, m_val_q, m_pin_d;
    pad_vec_t m_hist[$];

    always #5 clock = ~clock;

    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
        pulldown (pad[i]);
    end

    bidir_pad_reg dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tristate  (pad),
        .oe        (oe),
        .reg_val   (reg_val),
        .pin_in    (pin_in),
        .edge_rise (edge_rise),
        .edge_fall (edge_fall)
    );

    // Resolved pad level: our drive wins where enabled, else bench driver, else pulldown.
    function automatic pad_vec_t pad_model();
        return (m_oe_q & m_val_q) | (~m_oe_q & ext_en & ext_val);
    endfunction

    function automatic pad_vec_t rise_model();
`ifdef BIDIR_PAD_REG_EDGE_EN
        return ~m_oe_q & m_hist[S-1] & ~m_pin_d;
`else
        return '0;
`endif
    endfunction

    function automatic pad_vec_t fall_model();
`ifdef BIDIR_PAD_REG_EDGE_EN
        return ~m_oe_q & ~m_hist[S-1] & m_pin_d;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input pad_vec_t obs, input pad_vec_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model across the rising edge, then compare all outputs.
    task automatic tick();
        pad_vec_t pad_pre;
        pad_pre = pad_model();
        @(posedge clock);
        if (!reset_n) begin
            m_oe_q  = '0;
            m_val_q = '0;
            m_pin_d = '0;
            m_hist  = {};
            for (int k = 0; k < S; k++) m_hist.push_back('0);
        end else begin
            m_pin_d = m_hist[S-1];
            m_hist.push_front(pad_pre);
            void'(m_hist.pop_back());
            m_oe_q  = oe;
            m_val_q = reg_val;
        end
        @(negedge clock);
        chk("pad", pad, pad_model());
        chk("pin_in", pin_in, m_hist[S-1]);
        chk("edge_rise", edge_rise, rise_model());
        chk("edge_fall", edge_fall, fall_model());
    endtask

    initial begin
        pad_vec_t new_oe;
        pad_vec_t exp_pulse;

        m_oe_q = '0; m_val_q = '0; m_pin_d = '0;
        for (int k = 0; k < S; k++) m_hist.push_back('0);

`ifdef BIDIR_PAD_REG_EDGE_EN
        exp_pulse = 16'h0001;
`else
        exp_pulse = 16'h0000;
`endif

        // 1: held in reset with full drive requested -> everything released
        reset_n = 1'b0; oe = 16'hFFFF; reg_val = 16'hA5A5; ext_en = '0; ext_val = '0;
        repeat (3) tick();
        chk("t1_pad_released", pad, 16'h0000);
        chk("t1_pin_in_reset", pin_in, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk("t1_drive_after_release", pad, 16'hA5A5);

        // 2: low byte driven, high byte pulled down
        oe = 16'h00FF; reg_val = 16'h1234;
        tick();
        chk("t2_pad", pad, 16'h0034);
        repeat (2) tick();
        chk("t2_pin_in", pin_in, 16'h0034);

        // 3: externally driven edges on bit 0
        oe = 16'h0000;
        repeat (4) tick();
        ext_en = 16'h0001; ext_val = 16'h0001;
        repeat (2) tick();
        chk("t3_rise_pulse", edge_rise, exp_pulse);
        tick();
        chk("t3_rise_one_cycle", edge_rise, 16'h0000);
        ext_val = 16'h0000;
        repeat (2) tick();
        chk("t3_fall_pulse", edge_fall, exp_pulse);
        tick();
        chk("t3_fall_one_cycle", edge_fall, 16'h0000);

        // 4: own drive toggling is read back but never reported as an edge
        ext_en = '0; oe = 16'h0001; reg_val = 16'h0000;
        repeat (3) tick();
        reg_val = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_no_rise", edge_rise, 16'h0000);
        end
        chk("t4_pin_in", pin_in, 16'h0001);

        // 5: single-cycle reset mid-operation
        oe = 16'hFFFF; reg_val = 16'hFFFF;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("t5_reset_release", pad, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk("t5_resume", pad, 16'hFFFF);

        // 6: enable and value change together
        oe = 16'h0000; reg_val = 16'h0000;
        repeat (2) tick();
        chk("t6_before", pad, 16'h0000);
        oe = 16'hFFFF; reg_val = 16'h5555;
        tick();
        chk("t6_after", pad, 16'h5555);

        // Random traffic; the bench never drives a bit we drive now or next cycle.
        for (int n = 0; n < 400; n++) begin
            new_oe  = pad_vec_t'($urandom) & pad_vec_t'($urandom);
            reg_val = pad_vec_t'($urandom);
            ext_en  = pad_vec_t'($urandom) & ~m_oe_q & ~new_oe;
            ext_val = pad_vec_t'($urandom);
            oe      = new_oe;
            reset_n = ($urandom_range(0, 24) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bidir_pad_reg
